// File: rtl/cnn_pkg.sv
// cnn_pkg
//   Shared constants and types for the CNN layer datapath.
//   P1_* : pooling-1 output map geometry; C2_* : conv-2 kernel/window geometry.
//   p1_rd_state_t : phases of the P1 window reader.
//   p1_rd_tag_t   : per-read tag carried alongside memory latency.
package cnn_pkg;

  localparam int unsigned P1_MAP_W     = 12;
  localparam int unsigned C2_KERNEL    = 5;
  localparam int unsigned C2_OUT_W     = 8;
  localparam int unsigned P1_MEM_DEPTH = 144;

  // Field widths of the read-side tag (fixed by the conv-2 MAC interface).
  localparam int unsigned KC_W  = 3;
  localparam int unsigned WIN_W = 3;
  localparam int unsigned TAP_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } p1_rd_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAP_W-1:0] tap;
    logic [WIN_W-1:0] win_row;
    logic [WIN_W-1:0] win_col;
  } p1_rd_tag_t;

endpackage

// File: rtl/p1_window_reader_if.sv
// p1_window_reader_if
//   Control/read bus of the P1 window reader.
//   start, stall              : from the sequencer / conv-2 layer into the reader
//   rd_en, addr               : read request to the P1 output memory
//   rd_valid, tap, win_row,
//   win_col, tap_last         : tag of the data currently returned by memory
//   busy, done                : scan status
//   master = reader side, slave = consumer side.
interface p1_window_reader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  import cnn_pkg::*;

  logic              start;
  logic              stall;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic              rd_valid;
  logic [TAP_W-1:0]  tap;
  logic [WIN_W-1:0]  win_row;
  logic [WIN_W-1:0]  win_col;
  logic              tap_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, stall,
    output rd_en, addr, rd_valid, tap, win_row, win_col, tap_last, busy, done
  );

  modport slave (
    output start, stall,
    input  rd_en, addr, rd_valid, tap, win_row, win_col, tap_last, busy, done
  );

endinterface

// File: rtl/p1_window_reader_scan.sv
// win_scan_counter
//   Four-level nested wrap counter walking conv-2 windows in raster order:
//   kc (innermost) -> kr -> wc -> wr (outermost).
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero all levels (start of a scan)
//   en         : advance one position
//   kc,kr,wc,wr: current position
//   kc_wrap    : kc at its last value
//   kr_wrap    : kc and kr at their last values (window complete)
//   wc_wrap    : window complete and last column of windows
//   last       : final position of the whole scan
module win_scan_counter
  import cnn_pkg::*;
#(
  parameter int unsigned KERNEL = C2_KERNEL,
  parameter int unsigned OUT_W  = C2_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [KC_W-1:0]  kc,
  output logic [KC_W-1:0]  kr,
  output logic [WIN_W-1:0] wc,
  output logic [WIN_W-1:0] wr,
  output logic             kc_wrap,
  output logic             kr_wrap,
  output logic             wc_wrap,
  output logic             last
);

  localparam logic [KC_W-1:0]  K_MAX = KC_W'(KERNEL - 1);
  localparam logic [WIN_W-1:0] W_MAX = WIN_W'(OUT_W - 1);

  logic [KC_W-1:0]  kc_q, kc_d, kr_q, kr_d;
  logic [WIN_W-1:0] wc_q, wc_d, wr_q, wr_d;

  always_comb begin
    kc_wrap = (kc_q == K_MAX);
    kr_wrap = kc_wrap && (kr_q == K_MAX);
    wc_wrap = kr_wrap && (wc_q == W_MAX);
    last    = wc_wrap && (wr_q == W_MAX);
  end

  always_comb begin
    kc_d = kc_q;
    kr_d = kr_q;
    wc_d = wc_q;
    wr_d = wr_q;
    if (clear) begin
      kc_d = '0;
      kr_d = '0;
      wc_d = '0;
      wr_d = '0;
    end else if (en) begin
      kc_d = kc_wrap ? '0 : kc_q + 1'b1;
      if (kc_wrap) kr_d = kr_wrap ? '0 : kr_q + 1'b1;
      if (kr_wrap) wc_d = wc_wrap ? '0 : wc_q + 1'b1;
      if (wc_wrap) wr_d = last    ? '0 : wr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kc_q <= '0;
      kr_q <= '0;
      wc_q <= '0;
      wr_q <= '0;
    end else begin
      kc_q <= kc_d;
      kr_q <= kr_d;
      wc_q <= wc_d;
      wr_q <= wr_d;
    end
  end

  assign kc = kc_q;
  assign kr = kr_q;
  assign wc = wc_q;
  assign wr = wr_q;

endmodule

// File: rtl/p1_window_reader.sv
// p1_window_reader
//   Read-side address generator for the pooling-1 output memory. Walks every
//   KERNEL x KERNEL conv-2 window of the MAP_W x MAP_W map in raster order,
//   one read per cycle, and tags returned data for the conv-2 MAC.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : p1_window_reader_if master (start/stall in; read request,
//           returned-data tag and busy/done out)
module p1_window_reader
  import cnn_pkg::*;
#(
  parameter int unsigned MAP_W      = P1_MAP_W,
  parameter int unsigned KERNEL     = C2_KERNEL,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  p1_window_reader_if.master   bus
);

  localparam int unsigned      OUT_W    = MAP_W - KERNEL + 1;
  localparam int unsigned      DRAIN_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] KR_STEP  = ADDR_W'(MAP_W - KERNEL + 1);
  localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(KERNEL * KERNEL - 1);

  p1_rd_state_t state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  // addr_q: current read; row_base_q: kernel-row start in this window;
  // win_base_q: window origin; win_row_base_q: origin of window column 0.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] win_row_base_q, win_row_base_d;

  logic rd_en, start_ok;
  logic [KC_W-1:0]  kc, kr;
  logic [WIN_W-1:0] wc, wr;
  logic kc_wrap, kr_wrap, wc_wrap, scan_last;

  p1_rd_tag_t tag_in, tag_out;
  p1_rd_tag_t pipe_q [RD_LATENCY];
  p1_rd_tag_t pipe_d [RD_LATENCY];

  win_scan_counter #(
    .KERNEL (KERNEL),
    .OUT_W  (OUT_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .en      (rd_en),
    .kc      (kc),
    .kr      (kr),
    .wc      (wc),
    .wr      (wr),
    .kc_wrap (kc_wrap),
    .kr_wrap (kr_wrap),
    .wc_wrap (wc_wrap),
    .last    (scan_last)
  );

  always_comb begin
    rd_en    = (state_q == READ) && !bus.stall;
    start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:  if (start_ok) state_d = READ;
      READ: begin
        if (rd_en && scan_last) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(RD_LATENCY - 1)) state_d = DONE;
        else drain_d = drain_q + 1'b1;
      end
      DONE:  if (start_ok) state_d = READ;
      default: state_d = IDLE;
    endcase
  end

  // Incremental address walk: each wrap level reloads all inner bases from
  // the next outer base, so no (row*MAP_W) product is ever formed.
  always_comb begin
    addr_d         = addr_q;
    row_base_d     = row_base_q;
    win_base_d     = win_base_q;
    win_row_base_d = win_row_base_q;
    if (start_ok) begin
      addr_d         = BASE;
      row_base_d     = BASE;
      win_base_d     = BASE;
      win_row_base_d = BASE;
    end else if (rd_en && !scan_last) begin
      if (!kc_wrap) begin
        addr_d = addr_q + 1'b1;
      end else if (!kr_wrap) begin
        addr_d     = addr_q + KR_STEP;
        row_base_d = row_base_q + ROW_STEP;
      end else if (!wc_wrap) begin
        addr_d     = win_base_q + 1'b1;
        row_base_d = win_base_q + 1'b1;
        win_base_d = win_base_q + 1'b1;
      end else begin
        addr_d         = win_row_base_q + ROW_STEP;
        row_base_d     = win_row_base_q + ROW_STEP;
        win_base_d     = win_row_base_q + ROW_STEP;
        win_row_base_d = win_row_base_q + ROW_STEP;
      end
    end
  end

  // Tag pipe never stalls: issued reads always emerge RD_LATENCY later.
  always_comb begin
    tag_in = '0;
    if (rd_en) begin
      tag_in.valid   = 1'b1;
      tag_in.tap     = TAP_W'(kr) * TAP_W'(KERNEL) + TAP_W'(kc);
      tag_in.win_row = wr;
      tag_in.win_col = wc;
    end
    pipe_d[0] = tag_in;
    for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    tag_out = pipe_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      drain_q        <= '0;
      addr_q         <= BASE;
      row_base_q     <= BASE;
      win_base_q     <= BASE;
      win_row_base_q <= BASE;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      addr_q         <= addr_d;
      row_base_q     <= row_base_d;
      win_base_q     <= win_base_d;
      win_row_base_q <= win_row_base_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    bus.rd_en    = rd_en;
    bus.addr     = addr_q;
    bus.rd_valid = tag_out.valid;
    bus.tap      = tag_out.tap;
    bus.win_row  = tag_out.win_row;
    bus.win_col  = tag_out.win_col;
    bus.tap_last = tag_out.valid && (tag_out.tap == TAP_LAST);
    bus.busy     = (state_q == READ) || (state_q == DRAIN);
    bus.done     = (state_q == DONE);
  end

endmodule
